// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - merges pipeline and long-latency writebacks onto one register-file port.
// Optional WB_ZERO_REG_FILTER_EN: suppresses writes to and Busy tracking of register 0.
module wb_write_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK_WbArb,
  input  logic                     RST_WbArb,
  input  logic                     Pipe_WE,
  input  logic [4:0]               Pipe_Rd,
  input  logic [31:0]              Pipe_Data,
  output logic                     Pipe_Stall,
  input  logic                     LL_Valid,
  input  logic [4:0]               LL_Rd,
  input  logic [31:0]              LL_Data,
  output logic                     LL_Ready,
  input  logic                     LL_Issue,
  input  logic [4:0]               LL_Issue_Rd,
  output logic [4:0]               A3,
  output logic [31:0]              WD3,
  output logic                     WE3,
  output logic [31:0]              Busy,
  output logic [$clog2(DEPTH):0]   Fifo_Count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [4:0]    mem_rd_q   [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [4:0]    a3_q, a3_d;
  logic [31:0]   wd3_q, wd3_d;
  logic          we3_q, we3_d;
  logic [31:0]   busy_q, busy_d;

  logic        full, empty, push, pop, pipe_sel, wr_en;
  logic [4:0]  head_rd, sel_rd;
  logic [31:0] head_data, sel_data, set_mask, clr_mask;

  always_comb begin
    full      = (count_q == FULL_CNT);
    empty     = (count_q == '0);
    push      = LL_Valid & ~full;
    // A full FIFO must drain ahead of the pipeline or LL results could starve forever.
    pipe_sel  = Pipe_WE & ~full;
    pop       = (Pipe_WE & full) | (~Pipe_WE & ~empty);
    head_rd   = mem_rd_q[rd_ptr_q];
    head_data = mem_data_q[rd_ptr_q];
    sel_rd    = pipe_sel ? Pipe_Rd : head_rd;
    sel_data  = pipe_sel ? Pipe_Data : head_data;
    clr_mask  = pop ? ({31'b0, 1'b1} << head_rd) : 32'b0;
`ifdef WB_ZERO_REG_FILTER_EN
    wr_en     = (pipe_sel | pop) & (sel_rd != 5'd0);
    set_mask  = (LL_Issue && LL_Issue_Rd != 5'd0) ? ({31'b0, 1'b1} << LL_Issue_Rd) : 32'b0;
`else
    wr_en     = pipe_sel | pop;
    set_mask  = LL_Issue ? ({31'b0, 1'b1} << LL_Issue_Rd) : 32'b0;
`endif
    // Set wins over clear so a re-issue to the same register is not lost.
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    a3_d      = wr_en ? sel_rd : a3_q;
    wd3_d     = wr_en ? sel_data : wd3_q;
    we3_d     = wr_en;
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge CLK_WbArb or negedge RST_WbArb) begin
    if (!RST_WbArb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      a3_q     <= '0;
      wd3_q    <= '0;
      we3_q    <= 1'b0;
      busy_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
      we3_q    <= we3_d;
      busy_q   <= busy_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge CLK_WbArb) begin
    if (push) begin
      mem_rd_q[wr_ptr_q]   <= LL_Rd;
      mem_data_q[wr_ptr_q] <= LL_Data;
    end
  end

  assign Pipe_Stall = Pipe_WE & full;
  assign LL_Ready   = ~full;
  assign A3         = a3_q;
  assign WD3        = wd3_q;
  assign WE3        = we3_q;
  assign Busy       = busy_q;
  assign Fifo_Count = count_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - scoreboard bench for wb_write_arbiter.
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_data = '0;
  logic        pipe_stall;
  logic        ll_valid = 1'b0;
  logic [4:0]  ll_rd = '0;
  logic [31:0] ll_data = '0;
  logic        ll_ready;
  logic        ll_issue = 1'b0;
  logic [4:0]  ll_issue_rd = '0;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        we3;
  logic [31:0] busy;
  logic [2:0]  fifo_count;

  int n_pass = 0;
  int n_total = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  wb_write_arbiter #(.DEPTH(4)) dut (
    .CLK_WbArb(clk), .RST_WbArb(rst_n),
    .Pipe_WE(pipe_we), .Pipe_Rd(pipe_rd), .Pipe_Data(pipe_data), .Pipe_Stall(pipe_stall),
    .LL_Valid(ll_valid), .LL_Rd(ll_rd), .LL_Data(ll_data), .LL_Ready(ll_ready),
    .LL_Issue(ll_issue), .LL_Issue_Rd(ll_issue_rd),
    .A3(a3), .WD3(wd3), .WE3(we3), .Busy(busy), .Fifo_Count(fifo_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    #1;
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every register-file write must match the next expected write.
  always @(negedge clk) begin
    if (we3 === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got A3=%0d WD3=%0h expected no write", a3, wd3);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("wb_write", {27'b0, a3, wd3}, {27'b0, e});
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_we3", 64'(we3), 64'd0);
    chk("rst_a3", 64'(a3), 64'd0);
    chk("rst_wd3", 64'(wd3), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_ll_ready", 64'(ll_ready), 64'd1);
    chk("rel_stall", 64'(pipe_stall), 64'd0);

    // Single pipeline write
    step();
    pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    chk("t1_stall", 64'(pipe_stall), 64'd0);
    step();
    pipe_we = 1'b0;
    chk("t1_we3", 64'(we3), 64'd1);
    drain();

    // Long-latency issue, result, Busy lifecycle
    step();
    ll_issue = 1'b1; ll_issue_rd = 5'd9;
    step();
    ll_issue = 1'b0;
    chk("t2_busy_set", 64'(busy[9]), 64'd1);
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h1234;
    chk("t2_ll_ready", 64'(ll_ready), 64'd1);
    exp_q.push_back({5'd9, 32'h1234});
    step();
    ll_valid = 1'b0;
    chk("t2_busy_held", 64'(busy[9]), 64'd1);
    chk("t2_count1", 64'(fifo_count), 64'd1);
    chk("t2_no_early_we3", 64'(we3), 64'd0);
    step();
    chk("t2_busy_clr", 64'(busy[9]), 64'd0);
    chk("t2_count0", 64'(fifo_count), 64'd0);
    chk("t2_we3", 64'(we3), 64'd1);
    drain();

    // Fill FIFO under continuous pipeline writes, then full-FIFO stall and wrap
    for (int i = 0; i < 4; i++) begin
      step();
      pipe_we = 1'b1; pipe_rd = 5'd7; pipe_data = 32'hA000 + i;
      ll_valid = 1'b1; ll_rd = 5'(10 + i); ll_data = 32'h100 + i;
      exp_q.push_back({5'd7, 32'hA000 + i});
      chk("t3_fill_stall", 64'(pipe_stall), 64'd0);
    end
    step();
    pipe_data = 32'hA004; ll_rd = 5'd14; ll_data = 32'h104;
    chk("t3_count_full", 64'(fifo_count), 64'd4);
    chk("t3_ll_ready_lo", 64'(ll_ready), 64'd0);
    chk("t3_stall_hi", 64'(pipe_stall), 64'd1);
    exp_q.push_back({5'd10, 32'h100});
    step();
    chk("t3_stall_lo", 64'(pipe_stall), 64'd0);
    chk("t3_ll_ready_hi", 64'(ll_ready), 64'd1);
    chk("t3_count3", 64'(fifo_count), 64'd3);
    exp_q.push_back({5'd7, 32'hA004});
    step();
    pipe_we = 1'b0; ll_valid = 1'b0;
    chk("t3_count_refill", 64'(fifo_count), 64'd4);
    for (int i = 1; i < 5; i++) exp_q.push_back({5'(10 + i), 32'h100 + i});
    drain();
    chk("t3_count_empty", 64'(fifo_count), 64'd0);

    // Issue and clear of the same register on one edge
    step();
    ll_valid = 1'b1; ll_rd = 5'd3; ll_data = 32'h33;
    exp_q.push_back({5'd3, 32'h33});
    step();
    ll_valid = 1'b0;
    ll_issue = 1'b1; ll_issue_rd = 5'd3;
    step();
    ll_issue = 1'b0;
    chk("t4_busy3_kept", 64'(busy[3]), 64'd1);
    drain();

    // Asynchronous reset with entries in flight
    for (int i = 0; i < 3; i++) begin
      step();
      pipe_we = 1'b1; pipe_rd = 5'd8; pipe_data = 32'hB000 + i;
      ll_valid = 1'b1; ll_rd = 5'(20 + i); ll_data = 32'h200 + i;
      ll_issue = (i == 0); ll_issue_rd = 5'd21;
      exp_q.push_back({5'd8, 32'hB000 + i});
    end
    step();
    pipe_we = 1'b0; ll_valid = 1'b0; ll_issue = 1'b0;
    chk("t5_count3", 64'(fifo_count), 64'd3);
    chk("t5_busy21", 64'(busy[21]), 64'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_we3", 64'(we3), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_count", 64'(fifo_count), 64'd0);
    chk("t5_rst_a3", 64'(a3), 64'd0);
    chk("t5_pending", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5_rel_ready", 64'(ll_ready), 64'd1);
    chk("t5_rel_stall", 64'(pipe_stall), 64'd0);
    repeat (8) @(negedge clk);

    // Register 0 handling
    step();
    pipe_we = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hF00D;
    ll_issue = 1'b1; ll_issue_rd = 5'd0;
`ifndef WB_ZERO_REG_FILTER_EN
    exp_q.push_back({5'd0, 32'hF00D});
`endif
    step();
    pipe_we = 1'b0; ll_issue = 1'b0;
`ifdef WB_ZERO_REG_FILTER_EN
    chk("t6_we3_zero", 64'(we3), 64'd0);
    chk("t6_busy0", 64'(busy[0]), 64'd0);
`else
    chk("t6_we3_zero", 64'(we3), 64'd1);
    chk("t6_busy0", 64'(busy[0]), 64'd1);
`endif
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, long-latency result FIFO entries; power of two, minimum 2.
REQ-002 CLK_WbArb  input  1  single clock; all state updates on rising edge.
REQ-003 RST_WbArb  input  1  reset; asynchronous and active-low.
REQ-004 Pipe_WE  input  1  pipeline writeback request this cycle.
REQ-005 Pipe_Rd  input  5  pipeline destination register.
REQ-006 Pipe_Data  input  32  pipeline writeback data.
REQ-007 Pipe_Stall  output  1  pipeline write not taken; pipeline holds Pipe_WE/Pipe_Rd/Pipe_Data next cycle.
REQ-008 LL_Valid  input  1  long-latency unit result valid.
REQ-009 LL_Rd  input  5  long-latency destination register.
REQ-010 LL_Data  input  32  long-latency result data.
REQ-011 LL_Ready  output  1  FIFO accepts a result this cycle.
REQ-012 LL_Issue  input  1  long-latency op issued this cycle.
REQ-013 LL_Issue_Rd  input  5  destination of the issued op.
REQ-014 A3  output  5  register file write address.
REQ-015 WD3  output  32  register file write data.
REQ-016 WE3  output  1  register file write enable.
REQ-017 Busy  output  32  per-register pending long-latency write scoreboard.
REQ-018 Fifo_Count  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-019 The block SHALL merge both write sources onto the single register-file write port; A3/WD3/WE3 SHALL be registered, driven on the rising edge following selection.
REQ-020 LL_Ready SHALL equal (Fifo_Count < DEPTH); push SHALL occur when LL_Valid and LL_Ready; LL_Valid with LL_Ready low SHALL be held by the source.
REQ-021 Selection each cycle SHALL be: FIFO full and Pipe_WE -> pop head, Pipe_Stall=1; else Pipe_WE -> pipeline write, Pipe_Stall=0; else FIFO non-empty -> pop head; else WE3<=0.
REQ-022 Pipe_Stall SHALL be combinational and asserted only under the full-FIFO rule of REQ-021.
REQ-023 Push and pop in the same cycle SHALL leave Fifo_Count unchanged; pointers SHALL wrap modulo DEPTH; FIFO order SHALL be strict FIFO.
REQ-024 An accepted LL result SHALL reach WE3 no earlier than the second rising edge after acceptance.
REQ-025 Busy[LL_Issue_Rd] SHALL set on the edge where LL_Issue=1; Busy[r] SHALL clear on the edge a FIFO entry with Rd=r is selected; simultaneous set and clear of the same r SHALL leave it set.
REQ-026 Pipeline writes SHALL not modify Busy.
REQ-027 When no write is selected, A3 and WD3 SHALL hold their previous values with WE3=0.

Reset
REQ-028 RST_WbArb low SHALL immediately clear WE3, A3, WD3, Busy, Fifo_Count and both pointers, independent of clock; in-flight FIFO entries SHALL be discarded.
REQ-029 After reset release, LL_Ready SHALL be 1 and Pipe_Stall 0.

Configuration
REQ-030 With WB_ZERO_REG_FILTER_EN defined, any selected write with Rd=0 SHALL still be consumed (popped/acknowledged) but drive WE3=0, and LL_Issue with LL_Issue_Rd=0 SHALL not set Busy[0].
REQ-031 Without WB_ZERO_REG_FILTER_EN, Rd=0 writes and Busy[0] SHALL behave as for any other register.

Verification
REQ-032 Reset, single Pipe_WE Rd=5 Data=0xDEADBEEF -> next edge WE3=1, A3=5, WD3=0xDEADBEEF, Pipe_Stall=0.
REQ-033 LL_Issue Rd=9, then LL result Rd=9 Data=0x1234 with Pipe_WE idle -> Busy[9]=1 until WE3=1/A3=9/WD3=0x1234, then Busy[9]=0.
REQ-034 Fill FIFO with 4 results while Pipe_WE held high -> Fifo_Count=4, LL_Ready=0, Pipe_Stall=1 one cycle, head written; pipeline write follows next cycle.
REQ-035 Issue and clear of Rd=3 on the same edge -> Busy[3] remains 1.
REQ-036 Assert RST_WbArb with Fifo_Count=3 mid-cycle -> WE3=0, Busy=0, Fifo_Count=0 immediately, no stale writes after release.
REQ-037 Macro defined, Pipe_WE Rd=0 -> WE3 stays 0; macro undefined -> WE3=1, A3=0.
